// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and the
// microcode tables that reuse the opcode length decoder.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_CB,
    FETCH_LO,
    FETCH_HI,
    ISSUE
  } fetch_state_t;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  // Instruction length in bytes, excluding any 0xCB prefix handling.
  typedef enum logic [1:0] {
    LEN_1 = 2'd1,
    LEN_2 = 2'd2,
    LEN_3 = 2'd3
  } instr_len_t;

endpackage

// File: rtl/instr_len_mod.sv
// Combinational opcode-to-length decoder. Unlisted and illegal opcodes are
// treated as single-byte instructions.
module instr_len_mod
  import fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output instr_len_t len
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    len = LEN_1;
    case (opcode)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:
        len = LEN_2;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
        len = LEN_3;
      default: len = LEN_1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_mod.sv
// Instruction fetch stage: reads opcode/immediate bytes at the PC, folds the
// 0xCB prefix into a flag and issues one instruction over valid/ready.
module instr_fetch_mod
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic [15:0] imm,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic [15:0] jump_addr
);

  fetch_state_t state, state_next;
  logic [15:0]  pc;
  logic         is_len3;
  instr_len_t   rdata_len;

  instr_len_mod u_len (
    .opcode (mem_rdata),
    .len    (rdata_len)
  );

  assign mem_addr    = pc;
  assign mem_rd      = (state != ISSUE);
  assign instr_valid = (state == ISSUE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_OP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (jump) begin
      state_next = FETCH_OP;
    end else begin
      case (state)
        FETCH_OP: if (mem_ack) begin
          if (mem_rdata == CB_PREFIX)  state_next = FETCH_CB;
          else if (rdata_len == LEN_1) state_next = ISSUE;
          else                         state_next = FETCH_LO;
        end
        FETCH_CB: if (mem_ack) state_next = ISSUE;
        FETCH_LO: if (mem_ack) state_next = is_len3 ? FETCH_HI : ISSUE;
        FETCH_HI: if (mem_ack) state_next = ISSUE;
        ISSUE:    if (instr_ready) state_next = FETCH_OP;
        default:  state_next = FETCH_OP;
      endcase
    end
  end

  // Datapath; jump discards any byte acked in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      opcode    <= '0;
      cb_prefix <= 1'b0;
      imm       <= '0;
      instr_pc  <= '0;
      is_len3   <= 1'b0;
    end else if (jump) begin
      pc        <= jump_addr;
      imm       <= '0;
      cb_prefix <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: if (mem_ack) begin
          opcode   <= mem_rdata;
          instr_pc <= pc;
          pc       <= pc + 16'd1;
          is_len3  <= (rdata_len == LEN_3);
        end
        FETCH_CB: if (mem_ack) begin
          opcode    <= mem_rdata;
          cb_prefix <= 1'b1;
          pc        <= pc + 16'd1;
        end
        FETCH_LO: if (mem_ack) begin
          imm[7:0] <= mem_rdata;
          pc       <= pc + 16'd1;
        end
        FETCH_HI: if (mem_ack) begin
          imm[15:8] <= mem_rdata;
          pc        <= pc + 16'd1;
        end
        ISSUE: if (instr_ready) begin
          imm       <= '0;
          cb_prefix <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_mod.sv
// Directed bench for instr_fetch_mod: a vector table of whole instructions plus
// hand-written sequences for jump, wait-state, PC wrap and reset corners.
module tb_instr_fetch_mod;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic [15:0] imm;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [15:0] jump_addr;

  logic [7:0] mem [0:65535];
  logic       ack_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [15:0] ipc;
    int          len;   // cycles from start of fetch to instr_valid, zero-wait
    logic [15:0] next;  // mem_addr right after the handshake
    int          stall; // cycles to hold ready low once valid
  } vec_t;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_rd & ack_en;

  instr_fetch_mod #(.RESET_PC(16'h0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .opcode      (opcode),
    .cb_prefix   (cb_prefix),
    .imm         (imm),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_addr   (jump_addr)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0;
    while (!instr_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, v.len);
    check({tag, " opcode"}, opcode, v.op);
    check({tag, " cb_prefix"}, cb_prefix, v.cb);
    check({tag, " imm"}, imm, v.imm);
    check({tag, " instr_pc"}, instr_pc, v.ipc);
    check({tag, " mem_rd in issue"}, mem_rd, 1'b0);
    for (int k = 0; k < v.stall; k++) begin
      step();
      check({tag, " stall valid"}, instr_valid, 1'b1);
      check({tag, " stall mem_rd"}, mem_rd, 1'b0);
      check({tag, " stall opcode"}, opcode, v.op);
      check({tag, " stall cb"}, cb_prefix, v.cb);
      check({tag, " stall imm"}, imm, v.imm);
      check({tag, " stall pc"}, instr_pc, v.ipc);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check({tag, " valid after handshake"}, instr_valid, 1'b0);
    check({tag, " mem_rd after handshake"}, mem_rd, 1'b1);
    check({tag, " next addr"}, mem_addr, v.next);
  endtask

  vec_t vecs [8];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0100] = 8'h00;
    mem[16'h0101] = 8'hC3; mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
    mem[16'h0104] = 8'hCB; mem[16'h0105] = 8'h37;
    mem[16'h0106] = 8'h01; mem[16'h0107] = 8'hCD; mem[16'h0108] = 8'hAB;
    mem[16'h0109] = 8'h18; mem[16'h010A] = 8'h80;
    mem[16'h010B] = 8'hD3;
    mem[16'h010C] = 8'hCB; mem[16'h010D] = 8'h11;
    mem[16'h010E] = 8'hE0; mem[16'h010F] = 8'h42;
    mem[16'h0110] = 8'h3E; mem[16'h0111] = 8'h99;
    mem[16'h2000] = 8'h00;
    mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h55;
    mem[16'h0001] = 8'h00;
    mem[16'h3000] = 8'h06; mem[16'h3001] = 8'h77;
    mem[16'h3002] = 8'h00;
    mem[16'h4000] = 8'hCB; mem[16'h4001] = 8'h7C;
    mem[16'h4002] = 8'hC3;

    vecs[0] = '{8'h00, 1'b0, 16'h0000, 16'h0100, 1, 16'h0101, 0};
    vecs[1] = '{8'hC3, 1'b0, 16'h1234, 16'h0101, 3, 16'h0104, 0};
    vecs[2] = '{8'h37, 1'b1, 16'h0000, 16'h0104, 2, 16'h0106, 5};
    vecs[3] = '{8'h01, 1'b0, 16'hABCD, 16'h0106, 3, 16'h0109, 0};
    vecs[4] = '{8'h18, 1'b0, 16'h0080, 16'h0109, 2, 16'h010B, 0};
    vecs[5] = '{8'hD3, 1'b0, 16'h0000, 16'h010B, 1, 16'h010C, 0};
    vecs[6] = '{8'h11, 1'b1, 16'h0000, 16'h010C, 2, 16'h010E, 0};
    vecs[7] = '{8'hE0, 1'b0, 16'h0042, 16'h010E, 2, 16'h0110, 0};

    rst = 1'b1; ack_en = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_addr = '0;
    step();
    step();
    check("reset mem_addr", mem_addr, 16'h0100);
    check("reset mem_rd", mem_rd, 1'b1);
    check("reset instr_valid", instr_valid, 1'b0);
    check("reset opcode", opcode, 8'h00);
    check("reset imm", imm, 16'h0000);
    check("reset instr_pc", instr_pc, 16'h0000);
    check("reset cb_prefix", cb_prefix, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Jump coinciding with the immediate byte's ack: byte dropped, no issue.
    step();
    jump = 1'b1; jump_addr = 16'h2000;
    step();
    jump = 1'b0;
    check("jump imm valid", instr_valid, 1'b0);
    check("jump imm addr", mem_addr, 16'h2000);
    check("jump imm mem_rd", mem_rd, 1'b1);
    run_vec('{8'h00, 1'b0, 16'h0000, 16'h2000, 1, 16'h2001, 0}, "after jump");

    // Jump to the top of memory, then hold off acks to exercise wait states.
    jump = 1'b1; jump_addr = 16'hFFFF;
    step();
    jump = 1'b0;
    check("jump wrap addr", mem_addr, 16'hFFFF);
    ack_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("wait addr", mem_addr, 16'hFFFF);
      check("wait mem_rd", mem_rd, 1'b1);
      check("wait valid", instr_valid, 1'b0);
    end
    ack_en = 1'b1;
    run_vec('{8'h3E, 1'b0, 16'h0055, 16'hFFFF, 2, 16'h0001, 0}, "wrap");

    // Jump in ISSUE without ready: instruction dropped.
    step();
    check("issue before drop", instr_valid, 1'b1);
    jump = 1'b1; jump_addr = 16'h3000;
    step();
    jump = 1'b0;
    check("drop valid", instr_valid, 1'b0);
    check("drop addr", mem_addr, 16'h3000);
    run_vec('{8'h06, 1'b0, 16'h0077, 16'h3000, 2, 16'h3002, 0}, "after drop");

    // Jump coinciding with the handshake.
    step();
    check("issue before jump hs", instr_valid, 1'b1);
    jump = 1'b1; jump_addr = 16'h4000; instr_ready = 1'b1;
    step();
    jump = 1'b0; instr_ready = 1'b0;
    check("jump hs valid", instr_valid, 1'b0);
    check("jump hs addr", mem_addr, 16'h4000);
    run_vec('{8'h7C, 1'b1, 16'h0000, 16'h4000, 2, 16'h4002, 0}, "after jump hs");

    // Reset in the middle of a 3-byte fetch.
    step();
    rst = 1'b1;
    step();
    check("midreset addr", mem_addr, 16'h0100);
    check("midreset mem_rd", mem_rd, 1'b1);
    check("midreset valid", instr_valid, 1'b0);
    check("midreset opcode", opcode, 8'h00);
    check("midreset instr_pc", instr_pc, 16'h0000);
    check("midreset imm", imm, 16'h0000);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mod.md
# instr_fetch_mod

Instruction fetch stage for the CPU core. Reads opcode and immediate bytes from the memory bus at the program counter, folds the 0xCB prefix into a flag, and presents one complete instruction to the microcode lookup over a valid/ready handshake. Owns the fetch PC. The downstream microcode stage consumes `opcode` directly as its table index.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC value after reset.

Ports:
- `clk`, in, 1: sole clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `mem_addr`, out, 16: byte address of the current fetch. Always equals `pc`.
- `mem_rd`, out, 1: read request. High in every fetch state.
- `mem_rdata`, in, 8: read data. Valid in the cycle `mem_ack` is high.
- `mem_ack`, in, 1: read complete. Meaningful only while `mem_rd` is high.
- `opcode`, out, 8: primary opcode, or the second byte when the instruction is CB-prefixed.
- `cb_prefix`, out, 1: instruction was prefixed by 0xCB.
- `imm`, out, 16: immediate value, `{hi,lo}`. Unused bytes read as zero.
- `instr_pc`, out, 16: address of the instruction's first byte.
- `instr_valid`, out, 1: instruction outputs are valid.
- `instr_ready`, in, 1: consumer accepts the instruction.
- `jump`, in, 1: redirect request.
- `jump_addr`, in, 16: redirect target.

## Operation
- States: `FETCH_OP`, `FETCH_CB`, `FETCH_LO`, `FETCH_HI`, `ISSUE`.
- Reset state is `FETCH_OP` with `pc=RESET_PC`. All outputs are 0 except `mem_rd=1` and `mem_addr=RESET_PC`.
- Each fetch state holds `mem_rd=1`. On `mem_ack`:
  - capture `mem_rdata`;
  - `pc <= pc+1`, wrapping from 16'hFFFF to 16'h0000;
  - advance to the next state.
- Transitions out of `FETCH_OP` (on ack):
  - Byte 0xCB → `FETCH_CB`.
  - Otherwise, branch on instruction length: 1 → `ISSUE`, 2 → `FETCH_LO`, 3 → `FETCH_LO` followed by `FETCH_HI`.
  - `instr_pc` latches `pc` on entry to `FETCH_OP`.
- `FETCH_CB`: the captured byte becomes `opcode` and `cb_prefix=1`. All CB instructions are 2 bytes, so the next state is `ISSUE`.
- Length-2 opcodes: 06,0E,16,1E,26,2E,36,3E, 18,20,28,30,38, C6,CE,D6,DE,E6,EE,F6,FE, E0,F0,E8,F8.
- Length-3 opcodes: 01,11,21,31, 08, C2,C3,C4,CA,CC,CD, D2,D4,DA,DC, EA,FA.
- All other opcodes are length 1. Illegal opcodes (D3, DB, ...) are length 1; the fetch stage does not trap them.
- `ISSUE` behaviour:
  - `instr_valid=1`, `mem_rd=0`.
  - All instruction outputs stay stable until `instr_valid && instr_ready`.
  - On the handshake, go to `FETCH_OP`.
- `jump` has priority over every other event, in any state:
  - `pc <= jump_addr`, state `<= FETCH_OP`, and any in-flight byte is discarded, even if `mem_ack` is high in the same cycle.
  - If `jump` coincides with the `ISSUE` handshake, the instruction counts as consumed.
  - If `jump` occurs in `ISSUE` without `ready`, the instruction is dropped.
- `rst` mid-fetch or mid-issue returns every register to its reset value on that edge. It has priority over `jump`.
- `imm` and `cb_prefix` clear on entry to `FETCH_OP`.

## Timing
- Each byte takes one cycle if `mem_ack` is returned combinationally. Wait states stretch the fetch state.
- With zero-wait memory, `instr_valid` rises:
  - 1 cycle after the opcode ack for a 1-byte instruction;
  - 2 cycles after it for CB or 2-byte instructions;
  - 3 cycles after it for 3-byte instructions.
- After the handshake, the next `mem_rd` is issued the following cycle. Throughput is at best (length+1) cycles per instruction.
- `jump` takes effect on the next edge: `mem_addr=jump_addr` in the following cycle.

## Structure
- Package `fetch_pkg` holds:
  - the state enum;
  - `CB_PREFIX = 8'hCB`;
  - the 2-bit length encoding.
- One combinational sub-module, `instr_len_mod`, maps an 8-bit opcode to its length (1/2/3). It is kept separate so the microcode tables can share it.

## Test plan
- Reset with `RESET_PC=16'h0100` → `mem_addr=0x0100`, `mem_rd=1`, `instr_valid=0`.
- Memory returns 00 at 0x0100 with `ready=1` → `opcode=00`, `imm=0000`, `instr_pc=0100`, next fetch at 0x0101.
- Bytes C3 34 12 → `opcode=C3`, `imm=1234`, `cb_prefix=0`, next fetch at `instr_pc+3`.
- Bytes CB 37 → `opcode=37`, `cb_prefix=1`, `imm=0000`. Hold `ready` low for 5 cycles → outputs stable, `mem_rd=0` throughout.
- `jump=1`, `jump_addr=0x2000` in the same cycle as the `mem_ack` of an immediate byte → byte discarded, no `instr_valid`, next `mem_addr=0x2000`.
- PC at 0xFFFF fetching 3E 55 → `imm=0055`, PC wraps to 0x0001 after the immediate fetch.
